// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> load-use hazard scoreboard signal bundle.
// The pipeline (master) presents the ID-stage instruction and MEM/WB load
// writebacks; the scoreboard (slave) returns stall and status.
interface hazard_scoreboard_if;
  logic        IF_ID_valid;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
  logic [4:0]  IF_ID_rd;
  logic        IF_ID_memread;
  logic        flush;
  logic        MEM_WB_ldvalid;
  logic [4:0]  MEM_WB_rd;
  logic        stall;
  logic [31:0] busy;
  logic [2:0]  outstanding;
  logic        timeout;
  logic        protocol_err;

  modport master (
    output IF_ID_valid, IF_ID_rs1, IF_ID_rs2, IF_ID_rd, IF_ID_memread, flush,
           MEM_WB_ldvalid, MEM_WB_rd,
    input  stall, busy, outstanding, timeout, protocol_err
  );

  modport slave (
    input  IF_ID_valid, IF_ID_rs1, IF_ID_rs2, IF_ID_rd, IF_ID_memread, flush,
           MEM_WB_ldvalid, MEM_WB_rd,
    output stall, busy, outstanding, timeout, protocol_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: tracks registers awaiting load data, stalls the
// ID stage on a true dependency or a full load queue, and flags stuck stalls
// and bogus writebacks.
module hazard_scoreboard #(
  parameter int MAX_OUT = 4,   // outstanding load limit, 1..7
  parameter int TIMEOUT = 64   // consecutive stall cycles that raise timeout
) (
  input logic                 clk,
  input logic                 rst,
  hazard_scoreboard_if.slave  sb
);

  localparam int         CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

  typedef enum logic {RUN, STALL} state_e;

  state_e           state_q, state_d;
  logic [31:0]      busy_q, busy_d;
  logic [2:0]       outstanding_q, outstanding_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;
  logic             protocol_err_q, protocol_err_d;

  logic clr, issue, stall, haz_rs1, haz_rs2, full;

  // Hazard detection, stall and issue decode.
  always_comb begin
    clr     = sb.MEM_WB_ldvalid && (sb.MEM_WB_rd != 5'd0) && busy_q[sb.MEM_WB_rd];
    // A writeback landing this cycle is forwarded from MEM/WB, so it resolves
    // the dependency without a stall.
    haz_rs1 = (sb.IF_ID_rs1 != 5'd0) && busy_q[sb.IF_ID_rs1]
              && !(clr && (sb.MEM_WB_rd == sb.IF_ID_rs1));
    haz_rs2 = (sb.IF_ID_rs2 != 5'd0) && busy_q[sb.IF_ID_rs2]
              && !(clr && (sb.MEM_WB_rd == sb.IF_ID_rs2));
    full    = (outstanding_q == MAX_OUT_C);
    stall   = sb.IF_ID_valid && !sb.flush
              && (haz_rs1 || haz_rs2 || (sb.IF_ID_memread && full && !clr));
    issue   = sb.IF_ID_valid && !stall && !sb.flush && sb.IF_ID_memread
              && (sb.IF_ID_rd != 5'd0);
  end

  // Next-state for the scoreboard, load counter, stall FSM and sticky flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    busy_d         = busy_q;
    outstanding_d  = outstanding_q;
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    timeout_d      = timeout_q;
    protocol_err_d = protocol_err_q;

    // Clear first, then set, so a same-register set wins.
    if (clr)   busy_d[sb.MEM_WB_rd] = 1'b0;
    if (issue) busy_d[sb.IF_ID_rd]  = 1'b1;
    busy_d[0] = 1'b0;

    case ({issue, clr})
      2'b10:   if (outstanding_q != MAX_OUT_C) outstanding_d = outstanding_q + 3'd1;
      2'b01:   if (outstanding_q != 3'd0)      outstanding_d = outstanding_q - 3'd1;
      default: outstanding_d = outstanding_q;
    endcase

    if (sb.MEM_WB_ldvalid && ((sb.MEM_WB_rd == 5'd0) || !busy_q[sb.MEM_WB_rd]))
      protocol_err_d = 1'b1;

    if (stall && (stall_cnt_q == CNT_W'(TIMEOUT - 1)))
      timeout_d = 1'b1;

    // In RUN the counter is already 0, so entering STALL loads 1.
    case (state_q)
      RUN: begin
        state_d     = stall ? STALL : RUN;
        stall_cnt_d = stall ? CNT_W'(1) : '0;
      end
      STALL: begin
        state_d = stall ? STALL : RUN;
        if (!stall)
          stall_cnt_d = '0;
        else if (stall_cnt_q != CNT_W'(TIMEOUT))
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      default: begin
        state_d     = RUN;
        stall_cnt_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q        <= RUN;
      busy_q         <= '0;
      outstanding_q  <= '0;
      stall_cnt_q    <= '0;
      timeout_q      <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      outstanding_q  <= outstanding_d;
      stall_cnt_q    <= stall_cnt_d;
      timeout_q      <= timeout_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign sb.stall        = stall;
  assign sb.busy         = busy_q;
  assign sb.outstanding  = outstanding_q;
  assign sb.timeout      = timeout_q;
  assign sb.protocol_err = protocol_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (MAX_OUT=4, TIMEOUT=64).
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  hazard_scoreboard_if sb ();

  hazard_scoreboard #(.MAX_OUT(4), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb.slave)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one input vector and let combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic fl,
                       input logic ldv, input logic [4:0] wbrd);
    sb.IF_ID_valid    = v;
    sb.IF_ID_rs1      = rs1;
    sb.IF_ID_rs2      = rs2;
    sb.IF_ID_rd       = rd;
    sb.IF_ID_memread  = mr;
    sb.flush          = fl;
    sb.MEM_WB_ldvalid = ldv;
    sb.MEM_WB_rd      = wbrd;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    do_reset();
    vectors++;
    if (sb.busy !== 32'h0) begin
      miscompares++; $display("FAIL reset_busy: got %h expected %h", sb.busy, 32'h0);
    end
    vectors++;
    if (sb.outstanding !== 3'd0) begin
      miscompares++; $display("FAIL reset_outstanding: got %0d expected 0", sb.outstanding);
    end
    vectors++;
    if (sb.stall !== 1'b0 || sb.timeout !== 1'b0 || sb.protocol_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got stall=%b timeout=%b perr=%b expected 0 0 0",
               sb.stall, sb.timeout, sb.protocol_err);
    end
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 5, 1, 0, 0, 0);
    vectors++;
    if (sb.stall !== 1'b0) begin
      miscompares++; $display("FAIL lu_issue_stall: got %b expected 0", sb.stall);
    end
    tick();
    vectors++;
    if (sb.busy !== 32'h20 || sb.outstanding !== 3'd1) begin
      miscompares++;
      $display("FAIL lu_busy_set: got busy=%h out=%0d expected 00000020 1", sb.busy, sb.outstanding);
    end
    drive(1, 5, 0, 6, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (sb.stall !== 1'b1) begin
        miscompares++; $display("FAIL lu_stall_%0d: got %b expected 1", i, sb.stall);
      end
      tick();
    end
    drive(1, 5, 0, 6, 0, 0, 1, 5);
    vectors++;
    if (sb.stall !== 1'b0) begin
      miscompares++; $display("FAIL lu_wb_release: got %b expected 0", sb.stall);
    end
    tick();
    idle();
    vectors++;
    if (sb.busy !== 32'h0 || sb.outstanding !== 3'd0) begin
      miscompares++;
      $display("FAIL lu_cleared: got busy=%h out=%0d expected 00000000 0", sb.busy, sb.outstanding);
    end
  endtask

  task automatic test_x0();
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 3, 0, 0, 0, 0);
    vectors++;
    if (sb.busy !== 32'h0 || sb.outstanding !== 3'd0 || sb.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_load: got busy=%h out=%0d stall=%b expected 00000000 0 0",
               sb.busy, sb.outstanding, sb.stall);
    end
    tick();
    idle();
  endtask

  task automatic test_full();
    for (int r = 1; r <= 4; r++) begin
      drive(1, 0, 0, 5'(r), 1, 0, 0, 0);
      tick();
    end
    vectors++;
    if (sb.outstanding !== 3'd4 || sb.busy !== 32'h1E) begin
      miscompares++;
      $display("FAIL full_fill: got out=%0d busy=%h expected 4 0000001e", sb.outstanding, sb.busy);
    end
    drive(1, 0, 0, 6, 1, 0, 0, 0);
    vectors++;
    if (sb.stall !== 1'b1) begin
      miscompares++; $display("FAIL full_stall: got %b expected 1", sb.stall);
    end
    tick();
    vectors++;
    if (sb.outstanding !== 3'd4 || sb.busy !== 32'h1E) begin
      miscompares++;
      $display("FAIL full_hold: got out=%0d busy=%h expected 4 0000001e", sb.outstanding, sb.busy);
    end
    drive(1, 0, 0, 6, 1, 0, 1, 1);
    vectors++;
    if (sb.stall !== 1'b0) begin
      miscompares++; $display("FAIL full_wb_release: got %b expected 0", sb.stall);
    end
    tick();
    vectors++;
    if (sb.outstanding !== 3'd4 || sb.busy !== 32'h5C) begin
      miscompares++;
      $display("FAIL full_swap: got out=%0d busy=%h expected 4 0000005c", sb.outstanding, sb.busy);
    end
    for (int r = 2; r <= 6; r++) begin
      if (r != 5) begin
        drive(0, 0, 0, 0, 0, 0, 1, 5'(r));
        tick();
      end
    end
    idle();
    vectors++;
    if (sb.outstanding !== 3'd0 || sb.busy !== 32'h0 || sb.protocol_err !== 1'b0) begin
      miscompares++;
      $display("FAIL full_drain: got out=%0d busy=%h perr=%b expected 0 00000000 0",
               sb.outstanding, sb.busy, sb.protocol_err);
    end
  endtask

  task automatic test_set_clear();
    drive(1, 0, 0, 7, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 7, 1, 0, 1, 7);
    vectors++;
    if (sb.stall !== 1'b0) begin
      miscompares++; $display("FAIL sc_stall: got %b expected 0", sb.stall);
    end
    tick();
    vectors++;
    if (sb.busy !== 32'h80 || sb.outstanding !== 3'd1) begin
      miscompares++;
      $display("FAIL sc_same_reg: got busy=%h out=%0d expected 00000080 1", sb.busy, sb.outstanding);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    tick();
    idle();
    vectors++;
    if (sb.busy !== 32'h0 || sb.outstanding !== 3'd0) begin
      miscompares++;
      $display("FAIL sc_drain: got busy=%h out=%0d expected 00000000 0", sb.busy, sb.outstanding);
    end
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 8, 1, 0, 0, 0);
    tick();
    drive(1, 8, 0, 10, 1, 0, 0, 0);
    vectors++;
    if (sb.stall !== 1'b1) begin
      miscompares++; $display("FAIL fl_hazard: got %b expected 1", sb.stall);
    end
    drive(1, 8, 0, 10, 1, 1, 0, 0);
    vectors++;
    if (sb.stall !== 1'b0) begin
      miscompares++; $display("FAIL fl_squash_stall: got %b expected 0", sb.stall);
    end
    tick();
    vectors++;
    if (sb.busy !== 32'h100 || sb.outstanding !== 3'd1) begin
      miscompares++;
      $display("FAIL fl_no_set: got busy=%h out=%0d expected 00000100 1", sb.busy, sb.outstanding);
    end
    drive(1, 8, 0, 10, 1, 1, 1, 8);
    tick();
    idle();
    vectors++;
    if (sb.busy !== 32'h0 || sb.outstanding !== 3'd0) begin
      miscompares++;
      $display("FAIL fl_clear: got busy=%h out=%0d expected 00000000 0", sb.busy, sb.outstanding);
    end
  endtask

  task automatic test_timeout_err();
    drive(1, 0, 0, 12, 1, 0, 0, 0);
    tick();
    drive(1, 0, 12, 13, 0, 0, 0, 0);
    for (int i = 0; i < 63; i++) tick();
    vectors++;
    if (sb.timeout !== 1'b0 || sb.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL to_63: got timeout=%b stall=%b expected 0 1", sb.timeout, sb.stall);
    end
    tick();
    vectors++;
    if (sb.timeout !== 1'b1) begin
      miscompares++; $display("FAIL to_64: got %b expected 1", sb.timeout);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 12);
    tick();
    idle();
    tick();
    vectors++;
    if (sb.timeout !== 1'b1 || sb.stall !== 1'b0 || sb.busy !== 32'h0) begin
      miscompares++;
      $display("FAIL to_sticky: got timeout=%b stall=%b busy=%h expected 1 0 00000000",
               sb.timeout, sb.stall, sb.busy);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 9);
    tick();
    idle();
    vectors++;
    if (sb.protocol_err !== 1'b1 || sb.outstanding !== 3'd0 || sb.busy !== 32'h0) begin
      miscompares++;
      $display("FAIL perr_nonbusy: got perr=%b out=%0d busy=%h expected 1 0 00000000",
               sb.protocol_err, sb.outstanding, sb.busy);
    end
    do_reset();
    vectors++;
    if (sb.timeout !== 1'b0 || sb.protocol_err !== 1'b0) begin
      miscompares++;
      $display("FAIL flags_reset: got timeout=%b perr=%b expected 0 0", sb.timeout, sb.protocol_err);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    idle();
    vectors++;
    if (sb.protocol_err !== 1'b1) begin
      miscompares++; $display("FAIL perr_x0: got %b expected 1", sb.protocol_err);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 0, 0, 3, 1, 0, 0, 0);
    tick();
    drive(1, 3, 0, 4, 0, 0, 0, 0);
    tick();
    vectors++;
    if (sb.stall !== 1'b1) begin
      miscompares++; $display("FAIL rms_stall: got %b expected 1", sb.stall);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (sb.busy !== 32'h0 || sb.outstanding !== 3'd0 || sb.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rms_empty: got busy=%h out=%0d stall=%b expected 00000000 0 0",
               sb.busy, sb.outstanding, sb.stall);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_x0();
    test_full();
    test_set_clear();
    test_flush();
    test_timeout_err();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUT, default 4, meaning the maximum number of outstanding loads (range 1..7).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the number of consecutive stall cycles that raises the timeout flag.
REQ-003 SHALL use one clock and a synchronous active-high reset; ports clk and rst.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port IF_ID_valid, input, 1 bit: the ID stage holds a real instruction.
REQ-007 SHALL have ports IF_ID_rs1 and IF_ID_rs2, input, 5 bits each: the ID-stage source registers.
REQ-008 SHALL have port IF_ID_rd, input, 5 bits: the ID-stage destination register.
REQ-009 SHALL have port IF_ID_memread, input, 1 bit: the ID-stage instruction is a load.
REQ-010 SHALL have port flush, input, 1 bit: the ID instruction is being squashed (taken branch or jump).
REQ-011 SHALL have port MEM_WB_ldvalid, input, 1 bit: load data is being written back this cycle.
REQ-012 SHALL have port MEM_WB_rd, input, 5 bits: the destination of that load writeback.
REQ-013 SHALL have port stall, output, 1 bit: hold PC and IF_ID, and insert a bubble into ID_EX.
REQ-014 SHALL have port busy, output, 32 bits: the scoreboard; bit n is set while a load to xn is pending.
REQ-015 SHALL have port outstanding, output, 3 bits: the count of pending loads.
REQ-016 SHALL have port timeout, output, 1 bit: sticky flag for a stall persisting TIMEOUT cycles.
REQ-017 SHALL have port protocol_err, output, 1 bit: sticky flag for a writeback to a non-busy register, or to x0.

Function
REQ-018 SHALL form clr = MEM_WB_ldvalid && MEM_WB_rd != 0 && busy[MEM_WB_rd].
REQ-019 SHALL treat source rsX as hazarded when busy[rsX] is set, rsX != 0, and NOT (clr && MEM_WB_rd == rsX); a same-cycle writeback resolves the hazard because MEM_WB forwarding supplies the data.
REQ-020 SHALL assert stall combinationally when IF_ID_valid && !flush && (rs1 hazarded || rs2 hazarded || (IF_ID_memread && outstanding == MAX_OUT && !clr)).
REQ-021 SHALL form issue = IF_ID_valid && !stall && !flush && IF_ID_memread && IF_ID_rd != 0.
REQ-022 SHALL set busy[IF_ID_rd] on the next edge when issue is true.
REQ-023 SHALL clear busy[MEM_WB_rd] on the next edge when clr is true.
REQ-024 SHALL apply set over clear when set and clear hit the same register in one cycle; busy stays 1.
REQ-025 SHALL update outstanding as outstanding + issue - clr, with issue and clr both true leaving it unchanged.
REQ-026 SHALL never let outstanding exceed MAX_OUT or wrap below 0.
REQ-027 SHALL hold busy[0] at 0 permanently.
REQ-028 SHALL ignore a writeback to a non-busy register for busy and outstanding, set protocol_err, and set protocol_err for MEM_WB_ldvalid with MEM_WB_rd == 0.
REQ-029 SHALL run an FSM with states RUN and STALL: RUN goes to STALL when stall is 1; STALL goes to RUN when stall is 0.
REQ-030 SHALL implement stall_cnt as saturating at TIMEOUT, cleared on any cycle with stall == 0, and incremented each cycle with stall == 1.
REQ-031 SHALL set timeout on the edge where stall_cnt == TIMEOUT-1 and stall == 1; timeout then holds until rst.
REQ-032 SHALL give flush priority over a hazard: stall is 0, no busy bit is set by the squashed instruction, and pending loads still clear normally.

Reset
REQ-033 SHALL, while rst is 1 at an edge, reset busy to 0, outstanding to 0, the FSM to RUN, stall_cnt to 0, timeout to 0 and protocol_err to 0.
REQ-034 SHALL keep stall combinational: during rst it follows its equation, and after reset it evaluates to 0 because busy is 0 (unless a load arrives with outstanding at full).
REQ-035 SHALL let a reset mid-stall discard all pending entries; the first cycle after reset sees an empty scoreboard.

Verification
REQ-036 SHALL cover load-use: issue a load with rd=5, then next ID has rs1=5 -> stall=1 until MEM_WB_ldvalid with rd=5, with stall=0 in that same cycle; busy[5] is 0 after that edge.
REQ-037 SHALL cover x0: a load with rd=0, then rs1=0 -> no busy bit set, stall=0, outstanding stays 0.
REQ-038 SHALL cover full: with MAX_OUT=4, issue 4 loads to x1..x4 -> outstanding=4; a 5th load gives stall=1; a writeback of x1 in the same cycle gives stall=0, and outstanding stays 4.
REQ-039 SHALL cover set and clear together: busy[7]=1, writeback x7 while a new load to x7 issues -> busy[7] stays 1 and outstanding is unchanged.
REQ-040 SHALL cover flush: a hazarded instruction with flush=1 -> stall=0 and no new busy bit set.
REQ-041 SHALL cover timeout and error flags: hold a hazard 64 cycles with TIMEOUT=64 -> timeout=1 after cycle 64 and held after stall clears; a writeback of non-busy x9 -> protocol_err=1; rst clears both flags.
